dm_store_tracer: RTL and testbench
==================================

// Module: dm_store_tracer
// PURPOSE
//  Captures every data-memory store issued by the pipelined ARM core (DM_writeEnable,
//  DM_addr, DM_writeData) into a FIFO. Entries drain through a valid/ready port for a
//  debug consumer (UART dumper, testbench scoreboard).
//  Sits directly downstream of the core's data-memory interface, in parallel with dmem.
//  Purely observational: never stalls or alters the core.
// PARAMETERS
//  N        64     data/address width of the core's DM port
//  DEPTH    16     FIFO entries; power of two, >= 2
//  ADDR_LO  0      lowest byte address traced (inclusive)
//  ADDR_HI  511    highest byte address traced (inclusive)
// PORTS
//  CLOCK_50        in   1              system clock, all state on rising edge
//  reset           in   1              asynchronous, active-high; clears all state
//  DM_writeEnable  in   1              store strobe from core, one store per high cycle
//  DM_addr         in   N              store byte address
//  DM_writeData    in   N              store data
//  clear           in   1              sync: empty FIFO, zero drop_count, clear overflow
//  out_ready       in   1              consumer accepts head entry this cycle
//  out_valid       out  1              head entry valid
//  out_addr        out  N              head entry address
//  out_data        out  N              head entry data
//  count           out  $clog2(DEPTH)+1  entries held (0..DEPTH)
//  overflow        out  1              sticky: at least one in-window store dropped
//  drop_count      out  16             dropped stores, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (async, immediate): out_valid=0, out_addr=0, out_data=0, count=0, overflow=0,
//   drop_count=0, rd/wr pointers=0. Reset mid-drain discards all entries; no partial output.
//  in_win = (DM_addr >= ADDR_LO) && (DM_addr <= ADDR_HI), unsigned N-bit compare.
//  push_req = DM_writeEnable && in_win. Out-of-window stores are ignored and never counted.
//  pop = out_valid && out_ready. out_ready while out_valid=0 has no effect.
//  FIFO is first-word-fall-through. out_* come from registers/storage, never combinationally
//   from DM_* inputs: a store in cycle t appears on out_* no earlier than cycle t+1.
//  Push accept condition: push_req && (count<DEPTH || pop).
//   Full + pop + push in the same cycle: both take effect; count stays DEPTH.
//   Empty + push: out_valid rises next cycle. There is no same-cycle bypass.
//  Drop: push_req while count==DEPTH && !pop.
//   overflow<=1 (sticky); drop_count+=1, saturating at 16'hFFFF.
//  count' = count + push_accepted - pop. Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
//  out_addr/out_data hold stable while out_valid && !out_ready.
//   Values while out_valid=0 are don't-care; the bench must not check them.
//  clear (sync) has priority over push/pop in that cycle.
//   Next cycle: count=0, out_valid=0, overflow=0, drop_count=0.
//   A store coinciding with clear is discarded and not counted as a drop.
//  Ordering: entries exit in exact store order. There is no coalescing of same-address stores.
//  Throughput: one push and one pop per cycle sustained.
// TESTING
//  1 Reset: assert reset mid-cycle with 3 entries held.
//    -> all outputs 0 immediately, before the next clock edge.
//  2 Single store: addr=0x10, data=0xDEADBEEF, out_ready=0.
//    -> next cycle out_valid=1, out_addr=0x10, out_data=0xDEADBEEF, count=1.
//    Then out_ready=1 for one cycle -> count=0, out_valid=0.
//  3 Fill and overflow: 18 back-to-back stores, addr=8*i, data=i, out_ready=0.
//    -> count=16, overflow=1, drop_count=2.
//    Drain -> data 0..15 in order, then out_valid=0.
//  4 Full with simultaneous pop and push: FIFO full, out_ready=1 with store data=0x99.
//    -> count stays 16, no drop.
//    0x99 exits last after 15 more pops, i.e. the 16th pop from that point.
//  5 Window filter: stores at addr=0x200 and 0x1F8.
//    -> only 0x1F8 captured (count=1, drop_count=0).
//  6 Clear and wrap: clear with a coincident store -> count=0, drop_count=0.
//    Then 40 stores streamed with out_ready=1 -> all 40 exit in order.
//    Pointers wrap; overflow stays 0.

Source files
------------

// File: rtl/dm_store_tracer.sv
// Store tracer: captures in-window data-memory stores into a FWFT FIFO.
// Drains through a valid/ready port; drops are counted and never stall the core.
module dm_store_tracer #(
    parameter int              N       = 64,
    parameter int              DEPTH   = 16,
    parameter longint unsigned ADDR_LO = 0,
    parameter longint unsigned ADDR_HI = 511
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic                       DM_writeEnable,
    input  logic [N-1:0]               DM_addr,
    input  logic [N-1:0]               DM_writeData,
    input  logic                       clear,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [N-1:0]               out_addr,
    output logic [N-1:0]               out_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [15:0]                drop_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [N-1:0] LO = N'(ADDR_LO);
    localparam logic [N-1:0] HI = N'(ADDR_HI);

    logic [N-1:0]  mem_addr [DEPTH];
    logic [N-1:0]  mem_data [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    logic lo_ok;
    logic hi_ok;
    logic in_win;
    logic push_req;
    logic full;
    logic pop;
    logic push_ok;
    logic drop;

    // A zero lower bound needs no compare at all
    generate
        if (ADDR_LO == 0) begin : g_lo_open
            assign lo_ok = 1'b1;
        end else begin : g_lo_cmp
            assign lo_ok = (DM_addr >= LO);
        end
    endgenerate

    assign hi_ok    = (DM_addr <= HI);
    assign in_win   = lo_ok && hi_ok;
    assign push_req = DM_writeEnable && in_win;
    assign full     = (count == CW'(DEPTH));
    assign out_valid = (count != '0);
    assign pop      = out_valid && out_ready;
    assign push_ok  = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    // Head comes from storage; gated so reset/empty shows zeros
    assign out_addr = out_valid ? mem_addr[rd_ptr] : '0;
    assign out_data = out_valid ? mem_data[rd_ptr] : '0;

    always_ff @(posedge CLOCK_50) begin
        if (push_ok && !clear) begin
            mem_addr[wr_ptr] <= DM_addr;
            mem_data[wr_ptr] <= DM_writeData;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push_ok) - CW'(pop);
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) begin
                    drop_count <= drop_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dm_store_tracer.sv
// Directed bench for dm_store_tracer: reset, fill/overflow, full
// pop+push, window filter, clear and pointer wrap.
module tb_dm_store_tracer;

    logic        clk;
    logic        rst;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        clr;
    logic        rdy;
    logic        out_valid;
    logic [63:0] out_addr;
    logic [63:0] out_data;
    logic [4:0]  count;
    logic        overflow;
    logic [15:0] drop_count;

    int checks = 0;
    int errors = 0;

    dm_store_tracer dut (
        .CLOCK_50       (clk),
        .reset          (rst),
        .DM_writeEnable (we),
        .DM_addr        (addr),
        .DM_writeData   (wdata),
        .clear          (clr),
        .out_ready      (rdy),
        .out_valid      (out_valid),
        .out_addr       (out_addr),
        .out_data       (out_data),
        .count          (count),
        .overflow       (overflow),
        .drop_count     (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [63:0] a, input logic [63:0] d);
        we = 1'b1;
        addr = a;
        wdata = d;
        tick();
        we = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        we = 1'b0;
        addr = '0;
        wdata = '0;
        clr = 1'b0;
        rdy = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("init_valid", 64'(out_valid), 64'd0);
        chk("init_count", 64'(count), 64'd0);

        // 1: async reset with 3 entries held
        store(64'h8, 64'h1);
        store(64'h10, 64'h2);
        store(64'h18, 64'h3);
        chk("pre_rst_count", 64'(count), 64'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_addr", out_addr, 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_count", 64'(count), 64'd0);

        // 2: single store then one pop
        store(64'h10, 64'hDEADBEEF);
        chk("s_valid", 64'(out_valid), 64'd1);
        chk("s_addr", out_addr, 64'h10);
        chk("s_data", out_data, 64'hDEADBEEF);
        chk("s_count", 64'(count), 64'd1);
        tick();
        chk("s_hold_data", out_data, 64'hDEADBEEF);
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        chk("s_pop_count", 64'(count), 64'd0);
        chk("s_pop_valid", 64'(out_valid), 64'd0);

        // 3: 18 stores into a 16-deep FIFO
        for (int i = 0; i < 18; i++) begin
            store(64'(8 * i), 64'(i));
        end
        chk("f_count", 64'(count), 64'd16);
        chk("f_ovf", 64'(overflow), 64'd1);
        chk("f_drop", 64'(drop_count), 64'd2);
        rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("f_drain_valid", 64'(out_valid), 64'd1);
            chk("f_drain_data", out_data, 64'(i));
            chk("f_drain_addr", out_addr, 64'(8 * i));
            tick();
        end
        rdy = 1'b0;
        chk("f_empty_valid", 64'(out_valid), 64'd0);
        chk("f_ovf_sticky", 64'(overflow), 64'd1);

        // 4: full with simultaneous pop and push
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_ovf", 64'(overflow), 64'd0);
        chk("clr_drop", 64'(drop_count), 64'd0);
        for (int i = 0; i < 16; i++) begin
            store(64'(8 * i), 64'(100 + i));
        end
        chk("pp_full", 64'(count), 64'd16);
        rdy = 1'b1;
        store(64'h40, 64'h99);
        chk("pp_count", 64'(count), 64'd16);
        chk("pp_drop", 64'(drop_count), 64'd0);
        chk("pp_ovf", 64'(overflow), 64'd0);
        for (int k = 0; k < 15; k++) begin
            chk("pp_data", out_data, 64'(101 + k));
            tick();
        end
        chk("pp_last_valid", 64'(out_valid), 64'd1);
        chk("pp_last_data", out_data, 64'h99);
        chk("pp_last_addr", out_addr, 64'h40);
        tick();
        rdy = 1'b0;
        chk("pp_empty", 64'(out_valid), 64'd0);

        // 5: window filter
        store(64'h200, 64'h1);
        store(64'h1F8, 64'h2);
        chk("w_count", 64'(count), 64'd1);
        chk("w_drop", 64'(drop_count), 64'd0);
        chk("w_addr", out_addr, 64'h1F8);
        chk("w_data", out_data, 64'h2);
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        chk("w_empty", 64'(count), 64'd0);

        // 6: clear with coincident store, then 40-store stream
        for (int i = 0; i < 17; i++) begin
            store(64'(8 * i), 64'(i));
        end
        chk("c_pre_drop", 64'(drop_count), 64'd1);
        clr = 1'b1;
        we = 1'b1;
        addr = 64'h8;
        wdata = 64'h77;
        tick();
        clr = 1'b0;
        we = 1'b0;
        chk("c_count", 64'(count), 64'd0);
        chk("c_drop", 64'(drop_count), 64'd0);
        chk("c_ovf", 64'(overflow), 64'd0);
        chk("c_valid", 64'(out_valid), 64'd0);
        rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            we = 1'b1;
            addr = 64'(8 * i);
            wdata = 64'(1000 + i);
            tick();
            chk("st_valid", 64'(out_valid), 64'd1);
            chk("st_data", out_data, 64'(1000 + i));
            chk("st_addr", out_addr, 64'(8 * i));
            chk("st_count", 64'(count), 64'd1);
        end
        we = 1'b0;
        tick();
        rdy = 1'b0;
        chk("st_end_count", 64'(count), 64'd0);
        chk("st_ovf", 64'(overflow), 64'd0);
        chk("st_drop", 64'(drop_count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
